// File: rtl/mul_mac_seq.sv
// Dot-product sequencer for the multiplier: issues N MAC operations, an optional SAT MR,
// then reads MR0/MR1/MR2 back over the Rn path and returns the assembled MR value plus flags.
module mul_mac_seq #(
    parameter  int RF_DATASIZE = 16,
    parameter  int ADDR_W      = 4,
    parameter  int CNT_W       = 8,
    localparam int MR_W        = RF_DATASIZE * 5 / 2
) (
    input  logic                   clk_exe,
    input  logic                   reset,
    input  logic                   cmd_valid,
    output logic                   cmd_ready,
    input  logic [ADDR_W-1:0]      cmd_xbase,
    input  logic [ADDR_W-1:0]      cmd_ybase,
    input  logic [CNT_W-1:0]       cmd_len,
    input  logic [3:0]             cmd_dtsts,
    input  logic                   cmd_sub,
    input  logic                   cmd_clr,
    input  logic                   cmd_sat,
    input  logic                   stall,
    output logic [ADDR_W-1:0]      rf_rx_addr,
    output logic [ADDR_W-1:0]      rf_ry_addr,
    output logic                   ps_mul_en,
    output logic                   ps_mul_otreg,
    output logic [3:0]             ps_mul_dtsts,
    output logic [1:0]             ps_mul_cls,
    output logic [1:0]             ps_mul_sc,
    input  logic [RF_DATASIZE-1:0] mul_xb_dt,
    input  logic                   mul_ps_mv,
    input  logic                   mul_ps_mn,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [MR_W-1:0]        res_data,
    output logic                   res_mv,
    output logic                   res_mn,
    output logic                   busy
);

    localparam int MR2_W = MR_W - 2 * RF_DATASIZE;

    localparam logic [1:0] CLS_CTL  = 2'b00;
    localparam logic [1:0] CLS_MUL  = 2'b01;
    localparam logic [1:0] CLS_MADD = 2'b10;
    localparam logic [1:0] CLS_MSUB = 2'b11;

    localparam logic [1:0] SC_MR0 = 2'b00;
    localparam logic [1:0] SC_MR1 = 2'b01;
    localparam logic [1:0] SC_MR2 = 2'b10;
    localparam logic [1:0] SC_SAT = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_SAT,
        S_RD0,
        S_RD1,
        S_RD2,
        S_WAIT,
        S_DONE
    } state_e;

    typedef struct packed {
        logic [ADDR_W-1:0] xbase;
        logic [ADDR_W-1:0] ybase;
        logic [CNT_W-1:0]  len;
        logic [3:0]        dtsts;
        logic              sub;
        logic              clr;
        logic              sat;
    } cmd_t;

    // Tag of the previous cycle's issue; the multiplier answers one cycle later.
    typedef struct packed {
        logic       issued;
        logic       rd;
        logic [1:0] slice;
    } tag_t;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       idx_q, idx_d;
    cmd_t                   cmd_q, cmd_d;
    tag_t                   tag_q, tag_d;
    logic [RF_DATASIZE-1:0] mr0_q, mr0_d;
    logic [RF_DATASIZE-1:0] mr1_q, mr1_d;
    logic [MR2_W-1:0]       mr2_q, mr2_d;
    logic                   mv_q, mv_d;
    logic                   mn_q, mn_d;
    logic                   last_mac;
    logic                   unused_xb_hi;

    // Only the low MR2_W bits of the MR2 readback are meaningful.
    assign unused_xb_hi = ^mul_xb_dt[RF_DATASIZE-1:MR2_W];

    assign last_mac = (idx_q == cmd_q.len - CNT_W'(1));

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        cmd_d        = cmd_q;
        tag_d        = '0;
        mr0_d        = mr0_q;
        mr1_d        = mr1_q;
        mr2_d        = mr2_q;
        mv_d         = mv_q;
        mn_d         = mn_q;
        cmd_ready    = (state_q == S_IDLE) && !reset;
        rf_rx_addr   = '0;
        rf_ry_addr   = '0;
        ps_mul_en    = 1'b0;
        ps_mul_otreg = 1'b0;
        ps_mul_dtsts = '0;
        ps_mul_cls   = CLS_CTL;
        ps_mul_sc    = SC_MR0;
        res_valid    = 1'b0;

        if (tag_q.issued) begin
            if (tag_q.rd) begin
                unique case (tag_q.slice)
                    SC_MR0:  mr0_d = mul_xb_dt;
                    SC_MR1:  mr1_d = mul_xb_dt;
                    default: mr2_d = mul_xb_dt[MR2_W-1:0];
                endcase
            end else begin
                mv_d = mv_q | mul_ps_mv;
                mn_d = mul_ps_mn;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    cmd_d = '{xbase: cmd_xbase, ybase: cmd_ybase, len: cmd_len,
                              dtsts: cmd_dtsts, sub: cmd_sub, clr: cmd_clr, sat: cmd_sat};
                    idx_d = '0;
                    mv_d  = 1'b0;
                    if (cmd_len != '0)
                        state_d = S_MAC;
                    else if (cmd_sat)
                        state_d = S_SAT;
                    else
                        state_d = S_RD0;
                end
            end
            S_MAC: begin
                if (!stall) begin
                    ps_mul_en    = 1'b1;
                    ps_mul_otreg = 1'b1;
                    ps_mul_dtsts = cmd_q.dtsts;
                    if (idx_q == '0 && cmd_q.clr)
                        ps_mul_cls = CLS_MUL;
                    else if (cmd_q.sub)
                        ps_mul_cls = CLS_MSUB;
                    else
                        ps_mul_cls = CLS_MADD;
                    rf_rx_addr = cmd_q.xbase + ADDR_W'(idx_q);
                    rf_ry_addr = cmd_q.ybase + ADDR_W'(idx_q);
                    idx_d      = idx_q + CNT_W'(1);
                    tag_d      = '{issued: 1'b1, rd: 1'b0, slice: 2'b00};
                    if (last_mac)
                        state_d = cmd_q.sat ? S_SAT : S_RD0;
                end
            end
            S_SAT: begin
                if (!stall) begin
                    ps_mul_en    = 1'b1;
                    ps_mul_otreg = 1'b1;
                    ps_mul_dtsts = cmd_q.dtsts;
                    ps_mul_sc    = SC_SAT;
                    tag_d        = '{issued: 1'b1, rd: 1'b0, slice: 2'b00};
                    state_d      = S_RD0;
                end
            end
            S_RD0: begin
                if (!stall) begin
                    ps_mul_en    = 1'b1;
                    ps_mul_dtsts = cmd_q.dtsts;
                    ps_mul_sc    = SC_MR0;
                    tag_d        = '{issued: 1'b1, rd: 1'b1, slice: SC_MR0};
                    state_d      = S_RD1;
                end
            end
            S_RD1: begin
                if (!stall) begin
                    ps_mul_en    = 1'b1;
                    ps_mul_dtsts = cmd_q.dtsts;
                    ps_mul_sc    = SC_MR1;
                    tag_d        = '{issued: 1'b1, rd: 1'b1, slice: SC_MR1};
                    state_d      = S_RD2;
                end
            end
            S_RD2: begin
                if (!stall) begin
                    ps_mul_en    = 1'b1;
                    ps_mul_dtsts = cmd_q.dtsts;
                    ps_mul_sc    = SC_MR2;
                    tag_d        = '{issued: 1'b1, rd: 1'b1, slice: SC_MR2};
                    state_d      = S_WAIT;
                end
            end
            S_WAIT: state_d = S_DONE;
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_exe) begin
        if (reset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            cmd_q   <= '0;
            tag_q   <= '0;
            mr0_q   <= '0;
            mr1_q   <= '0;
            mr2_q   <= '0;
            mv_q    <= 1'b0;
            mn_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cmd_q   <= cmd_d;
            tag_q   <= tag_d;
            mr0_q   <= mr0_d;
            mr1_q   <= mr1_d;
            mr2_q   <= mr2_d;
            mv_q    <= mv_d;
            mn_q    <= mn_d;
        end
    end

    assign res_data = {mr2_q, mr1_q, mr0_q};
    assign res_mv   = mv_q;
    assign res_mn   = mn_q;
    assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_mul_mac_seq.sv
// Bench for mul_mac_seq: behavioural multiplier + register file, table of commands,
// issue and result scoreboards, plus hand sequences for reset and hold corners.
module tb_mul_mac_seq;

    localparam int DW = 16;
    localparam int AW = 4;
    localparam int CW = 8;
    localparam int MW = DW * 5 / 2;

    logic          clk_exe = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [AW-1:0] cmd_xbase = '0;
    logic [AW-1:0] cmd_ybase = '0;
    logic [CW-1:0] cmd_len = '0;
    logic [3:0]    cmd_dtsts = '0;
    logic          cmd_sub = 1'b0;
    logic          cmd_clr = 1'b0;
    logic          cmd_sat = 1'b0;
    logic          stall = 1'b0;
    logic [AW-1:0] rf_rx_addr, rf_ry_addr;
    logic          ps_mul_en, ps_mul_otreg;
    logic [3:0]    ps_mul_dtsts;
    logic [1:0]    ps_mul_cls, ps_mul_sc;
    logic [DW-1:0] mul_xb_dt = '0;
    logic          mul_ps_mv = 1'b0;
    logic          mul_ps_mn = 1'b0;
    logic          res_valid;
    logic          res_ready = 1'b0;
    logic [MW-1:0] res_data;
    logic          res_mv, res_mn, busy;

    always #5 clk_exe = ~clk_exe;

    mul_mac_seq #(.RF_DATASIZE(DW), .ADDR_W(AW), .CNT_W(CW)) dut (
        .clk_exe(clk_exe), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_xbase(cmd_xbase), .cmd_ybase(cmd_ybase), .cmd_len(cmd_len),
        .cmd_dtsts(cmd_dtsts), .cmd_sub(cmd_sub), .cmd_clr(cmd_clr), .cmd_sat(cmd_sat),
        .stall(stall),
        .rf_rx_addr(rf_rx_addr), .rf_ry_addr(rf_ry_addr),
        .ps_mul_en(ps_mul_en), .ps_mul_otreg(ps_mul_otreg), .ps_mul_dtsts(ps_mul_dtsts),
        .ps_mul_cls(ps_mul_cls), .ps_mul_sc(ps_mul_sc),
        .mul_xb_dt(mul_xb_dt), .mul_ps_mv(mul_ps_mv), .mul_ps_mn(mul_ps_mn),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .res_mv(res_mv), .res_mn(res_mn), .busy(busy)
    );

    int n_checks = 0;
    int n_err    = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    // Register file and multiplier model (integer mode, 40-bit MR).
    logic [DW-1:0] rf_x [16];
    logic [DW-1:0] rf_y [16];
    logic [MW-1:0] mr_m = '0;

    function automatic logic [MW-1:0] ext(input logic [DW-1:0] v, input logic sgn);
        return sgn ? {{(MW-DW){v[DW-1]}}, v} : {{(MW-DW){1'b0}}, v};
    endfunction

    function automatic logic ovf(input logic [MW-1:0] v, input logic sgn);
        if (sgn) return !((&v[MW-1:DW-1]) || !(|v[MW-1:DW-1]));
        return |v[MW-1:DW];
    endfunction

    always @(posedge clk_exe) begin : mul_model
        logic [MW-1:0] p, n;
        logic          sgn;
        if (ps_mul_en) begin
            sgn = ps_mul_dtsts[3] | ps_mul_dtsts[2];
            p   = ext(rf_x[rf_rx_addr], ps_mul_dtsts[2]) * ext(rf_y[rf_ry_addr], ps_mul_dtsts[3]);
            if (ps_mul_otreg && ps_mul_cls != 2'b00) begin
                case (ps_mul_cls)
                    2'b01:   n = p;
                    2'b10:   n = mr_m + p;
                    default: n = mr_m - p;
                endcase
                mr_m      <= n;
                mul_ps_mv <= ovf(n, sgn);
                mul_ps_mn <= n[MW-1];
            end else if (ps_mul_otreg && ps_mul_sc == 2'b11) begin
                n = mr_m;
                if (ovf(mr_m, sgn)) begin
                    if (sgn) n = mr_m[MW-1] ? {{(MW-DW+1){1'b1}}, {(DW-1){1'b0}}}
                                            : {{(MW-DW+1){1'b0}}, {(DW-1){1'b1}}};
                    else     n = {{(MW-DW){1'b0}}, {DW{1'b1}}};
                end
                mr_m      <= n;
                mul_ps_mv <= 1'b0;
                mul_ps_mn <= n[MW-1];
            end else if (!ps_mul_otreg) begin
                case (ps_mul_sc)
                    2'b00:   mul_xb_dt <= mr_m[DW-1:0];
                    2'b01:   mul_xb_dt <= mr_m[2*DW-1:DW];
                    default: mul_xb_dt <= {{(3*DW-MW){1'b0}}, mr_m[MW-1:2*DW]};
                endcase
            end
        end
    end

    typedef struct packed {
        logic [1:0]    cls;
        logic [1:0]    sc;
        logic          otreg;
        logic [3:0]    dtsts;
        logic [AW-1:0] rx;
        logic [AW-1:0] ry;
    } iss_t;

    typedef struct {
        logic [MW-1:0] data;
        logic          mv;
        logic          mn;
        int            lat;
    } res_t;

    typedef struct {
        logic [AW-1:0] xb, yb;
        logic [CW-1:0] len;
        logic [3:0]    dt;
        logic          sub, clr, sat;
        logic [15:0]   stall_mask;
        logic [MW-1:0] exp_data;
        logic          exp_mv, exp_mn;
        int            exp_lat;
    } vec_t;

    iss_t iss_q[$];
    res_t res_q[$];

    always @(negedge clk_exe) begin : issue_mon
        iss_t got, e;
        if (ps_mul_en) begin
            got = '{cls: ps_mul_cls, sc: ps_mul_sc, otreg: ps_mul_otreg,
                    dtsts: ps_mul_dtsts, rx: rf_rx_addr, ry: rf_ry_addr};
            if (iss_q.size() == 0) begin
                chk("extra_issue", 64'(got), 64'h0);
            end else begin
                e = iss_q.pop_front();
                chk("issue", 64'(got), 64'(e));
            end
        end
    end

    task automatic push_issues(input vec_t v);
        logic [1:0] c;
        for (int i = 0; i < int'(v.len); i++) begin
            c = (i == 0 && v.clr) ? 2'b01 : (v.sub ? 2'b11 : 2'b10);
            iss_q.push_back('{cls: c, sc: 2'b00, otreg: 1'b1, dtsts: v.dt,
                              rx: AW'(int'(v.xb) + i), ry: AW'(int'(v.yb) + i)});
        end
        if (v.sat) iss_q.push_back('{cls: 2'b00, sc: 2'b11, otreg: 1'b1, dtsts: v.dt, rx: '0, ry: '0});
        for (int k = 0; k < 3; k++)
            iss_q.push_back('{cls: 2'b00, sc: 2'(k), otreg: 1'b0, dtsts: v.dt, rx: '0, ry: '0});
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        res_t e;
        bit   got;
        int   lat;
        push_issues(v);
        res_q.push_back('{data: v.exp_data, mv: v.exp_mv, mn: v.exp_mn, lat: v.exp_lat});
        @(posedge clk_exe); #1;
        chk({nm, "_ready"}, 64'(cmd_ready), 64'h1);
        cmd_valid = 1'b1; cmd_xbase = v.xb; cmd_ybase = v.yb; cmd_len = v.len;
        cmd_dtsts = v.dt; cmd_sub = v.sub; cmd_clr = v.clr; cmd_sat = v.sat;
        @(posedge clk_exe); #1;
        cmd_valid = 1'b0;
        got = 0; lat = 0;
        for (int c = 1; c <= 60 && !got; c++) begin
            if (c > 1) begin @(posedge clk_exe); #1; end
            stall = (c < 16) ? v.stall_mask[c] : 1'b0;
            @(negedge clk_exe);
            if (res_valid) begin got = 1; lat = c; end
        end
        stall = 1'b0;
        e = res_q.pop_front();
        if (!got) begin
            chk({nm, "_timeout"}, 64'h0, 64'h1);
            iss_q.delete();
            return;
        end
        chk({nm, "_lat"}, 64'(lat), 64'(e.lat));
        chk({nm, "_data"}, 64'(res_data), 64'(e.data));
        chk({nm, "_mv"}, 64'(res_mv), 64'(e.mv));
        chk({nm, "_mn"}, 64'(res_mn), 64'(e.mn));
        // Result must hold and new commands must be refused while unacknowledged.
        cmd_valid = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk_exe); #1;
            @(negedge clk_exe);
            chk({nm, "_hold_valid"}, 64'(res_valid), 64'h1);
            chk({nm, "_hold_ready"}, 64'(cmd_ready), 64'h0);
            chk({nm, "_hold_data"}, 64'(res_data), 64'(e.data));
        end
        @(posedge clk_exe); #1;
        cmd_valid = 1'b0;
        res_ready = 1'b1;
        @(posedge clk_exe); #1;
        res_ready = 1'b0;
        @(negedge clk_exe);
        chk({nm, "_idle_busy"}, 64'(busy), 64'h0);
        chk({nm, "_idle_valid"}, 64'(res_valid), 64'h0);
        chk({nm, "_issues_left"}, 64'(iss_q.size()), 64'h0);
        iss_q.delete();
    endtask

    task automatic set_rf_dot();
        for (int i = 0; i < 16; i++) begin rf_x[i] = '0; rf_y[i] = '0; end
        rf_x[0] = 16'd2; rf_x[1] = 16'd3; rf_x[2] = 16'd4;
        rf_y[4] = 16'd5; rf_y[5] = 16'd6; rf_y[6] = 16'd7;
    endtask

    task automatic set_rf_sat();
        for (int i = 0; i < 16; i++) begin rf_x[i] = '0; rf_y[i] = '0; end
        rf_x[15] = 16'h7FFF; rf_x[0] = 16'h7FFF; rf_x[1] = 16'h7FFF;
        rf_y[14] = 16'h7FFF; rf_y[15] = 16'h7FFF; rf_y[0] = 16'h7FFF;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end

    vec_t vt[5];

    initial begin : main
        vt[0] = '{xb: 4'd0, yb: 4'd4, len: 8'd3, dt: 4'b0000, sub: 0, clr: 1, sat: 0,
                  stall_mask: 16'h0000, exp_data: 40'h38, exp_mv: 0, exp_mn: 0, exp_lat: 8};
        vt[1] = '{xb: 4'd0, yb: 4'd4, len: 8'd1, dt: 4'b0000, sub: 1, clr: 0, sat: 0,
                  stall_mask: 16'h0000, exp_data: 40'h2E, exp_mv: 0, exp_mn: 0, exp_lat: 6};
        vt[2] = '{xb: 4'd0, yb: 4'd4, len: 8'd3, dt: 4'b0000, sub: 0, clr: 1, sat: 0,
                  stall_mask: 16'h000C, exp_data: 40'h38, exp_mv: 0, exp_mn: 0, exp_lat: 10};
        vt[3] = '{xb: 4'd15, yb: 4'd14, len: 8'd3, dt: 4'b1100, sub: 0, clr: 1, sat: 1,
                  stall_mask: 16'h0000, exp_data: 40'h7FFF, exp_mv: 1, exp_mn: 0, exp_lat: 9};
        vt[4] = '{xb: 4'd0, yb: 4'd0, len: 8'd0, dt: 4'b0000, sub: 0, clr: 0, sat: 0,
                  stall_mask: 16'h0000, exp_data: 40'h7FFF, exp_mv: 0, exp_mn: 0, exp_lat: 5};

        set_rf_dot();
        repeat (3) @(posedge clk_exe);
        #1;
        @(negedge clk_exe);
        chk("rst_cmd_ready", 64'(cmd_ready), 64'h0);
        chk("rst_res_valid", 64'(res_valid), 64'h0);
        chk("rst_res_data", 64'(res_data), 64'h0);
        chk("rst_res_flags", 64'({res_mv, res_mn}), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        chk("rst_ps", 64'({ps_mul_en, ps_mul_otreg, ps_mul_dtsts, ps_mul_cls, ps_mul_sc,
                             rf_rx_addr, rf_ry_addr}), 64'h0);
        @(posedge clk_exe); #1;
        reset = 1'b0;

        for (int i = 0; i < 5; i++) begin
            if (i == 3) set_rf_sat();
            run_vec(vt[i], $sformatf("vec%0d", i));
        end

        // Reset during the second MAC issue abandons the command.
        set_rf_dot();
        iss_q.push_back('{cls: 2'b01, sc: 2'b00, otreg: 1'b1, dtsts: 4'b0000, rx: 4'd0, ry: 4'd4});
        iss_q.push_back('{cls: 2'b10, sc: 2'b00, otreg: 1'b1, dtsts: 4'b0000, rx: 4'd1, ry: 4'd5});
        @(posedge clk_exe); #1;
        cmd_valid = 1'b1; cmd_xbase = 4'd0; cmd_ybase = 4'd4; cmd_len = 8'd3;
        cmd_dtsts = 4'b0000; cmd_sub = 1'b0; cmd_clr = 1'b1; cmd_sat = 1'b0;
        @(posedge clk_exe); #1;
        cmd_valid = 1'b0;
        @(posedge clk_exe); #1;
        reset = 1'b1;
        @(negedge clk_exe);
        chk("rstmid_en_before", 64'(ps_mul_en), 64'h1);
        @(posedge clk_exe); #1;
        @(negedge clk_exe);
        chk("rstmid_en", 64'(ps_mul_en), 64'h0);
        chk("rstmid_busy", 64'(busy), 64'h0);
        chk("rstmid_valid", 64'(res_valid), 64'h0);
        chk("rstmid_ready_in_reset", 64'(cmd_ready), 64'h0);
        @(posedge clk_exe); #1;
        reset = 1'b0;
        @(negedge clk_exe);
        chk("rstmid_ready_after", 64'(cmd_ready), 64'h1);
        chk("rstmid_issues_left", 64'(iss_q.size()), 64'h0);
        iss_q.delete();
        run_vec(vt[0], "after_rst");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
        $finish;
    end

endmodule

// File: doc/mul_mac_seq.md
Name: mul_mac_seq

Overview:
- Command-driven sequencer for the multiplier unit.
- Accepts one dot-product command, then drives the multiplier control strobes and register-file read addresses for N multiply/accumulate issues.
- Optionally issues SAT MR, then reads MR0/MR1/MR2 back over the multiplier's Rn output path and returns the 40-bit MR value plus flags.
- Sits between the program sequencer command path and the multiplier; the register-file x/y read data goes straight to the multiplier, not through this block.

Parameters:
- RF_DATASIZE, 16, multiplier data width; MR and result width is RF_DATASIZE*5/2.
- ADDR_W, 4, register-file index width.
- CNT_W, 8, command length width.

Ports:
- clk_exe  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  high only in IDLE and reset low
- cmd_xbase  in  ADDR_W  first Rx register index
- cmd_ybase  in  ADDR_W  first Ry register index
- cmd_len  in  CNT_W  number of products; 0 = no MAC issues
- cmd_dtsts  in  4  data-status code passed to ps_mul_dtsts ({ryUbS,rxUbS,IbF,rnd})
- cmd_sub  in  1  accumulate-subtract (1) / accumulate-add (0)
- cmd_clr  in  1  first issue is a plain product (MR overwritten)
- cmd_sat  in  1  issue SAT MR after the last MAC
- stall  in  1  suppress issue this cycle
- rf_rx_addr  out  ADDR_W  Rx read index
- rf_ry_addr  out  ADDR_W  Ry read index
- ps_mul_en  out  1  multiplier enable
- ps_mul_otreg  out  1  multiplier output-register select
- ps_mul_dtsts  out  4  multiplier data status
- ps_mul_cls  out  2  multiplier operation class
- ps_mul_sc  out  2  multiplier sub-class
- mul_xb_dt  in  RF_DATASIZE  multiplier Rn output
- mul_ps_mv  in  1  multiplier overflow flag
- mul_ps_mn  in  1  multiplier sign flag
- res_valid  out  1  result available
- res_ready  in  1  result accept
- res_data  out  RF_DATASIZE*5/2  {MR2[7:0], MR1, MR0}
- res_mv  out  1  sticky overflow
- res_mn  out  1  final sign flag
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset=1 at an edge):
  - state goes to IDLE; idx=0.
  - res_valid, res_data, res_mv, res_mn go to 0.
  - All ps_* outputs and rf addresses are 0; cmd_ready=0 while reset is high.
  - Reset mid-operation abandons the command; ps_mul_en is 0 from the next cycle. MR contents inside the multiplier are not touched.
- ps_*, rf_* and cmd_ready are combinational decodes of the state register, idx and stall. Issue and multiplier latch happen at the same edge.
- In any issuing state with stall=1: ps_mul_en=0, state and idx hold.
- IDLE: cmd_ready=1, ps_mul_en=0.
  - On cmd_valid&cmd_ready, latch all cmd_* fields, idx=0, mv_sticky=0.
  - Next state: MAC if cmd_len!=0, else SAT if cmd_sat, else RD0.
- MAC: ps_mul_en=1, otreg=1, dtsts=latched dtsts, sc=00.
  - cls=01 if (idx==0 & clr), else 11 if sub, else 10.
  - rf_rx_addr=xbase+idx, rf_ry_addr=ybase+idx, both modulo 2^ADDR_W (wrap).
  - idx++ per issue. After the issue with idx==len-1, go to SAT if sat, else RD0.
- SAT: one issue with cls=00, sc=11, otreg=1.
- RD0/RD1/RD2: one issue each with cls=00, otreg=0, sc=00/01/10 respectively; RD2 goes to WAIT.
- Readback capture:
  - A registered tag (issued, slice) is delayed one cycle.
  - The cycle after an RDk issue, mul_xb_dt is captured into slice k at the next edge; MR2 keeps only [7:0].
  - The cycle after each MAC or SAT issue, mv_sticky |= mul_ps_mv and mn_last = mul_ps_mn.
- WAIT: no issue; completes the RD2 capture, then DONE.
- DONE: res_valid=1; res_data, res_mv and res_mn are stable until res_valid&res_ready, then IDLE.
  - cmd_valid in DONE is not accepted (cmd_ready=0).
- Latency with no stall: command accepted at edge 0 → res_valid from cycle len+5 (len+6 if sat).
  - len=0 with sat=0: res_valid at cycle 5.
  - Each stall cycle adds one.
- Stall during WAIT or DONE has no effect.

Test Plan:
- UUI dot product: RF x[0..2]=2,3,4, y[4..6]=5,6,7; cmd xbase=0, ybase=4, len=3, dtsts=0000, clr=1, sub=0, sat=0 → three MAC issues with cls 01,10,10; res_data=40'h38; res_mv=0; res_valid at cycle 8.
- Subtract-accumulate: following the previous test, cmd len=1, clr=0, sub=1, x[0]=2, y[4]=5 → cls=11; res_data=40'h2E.
- Stall: the first test with stall=1 on cycles 2 and 3 → ps_mul_en low those cycles; idx held; same res_data=40'h38; res_valid at cycle 10.
- Address wrap and saturate: xbase=15, ybase=14, len=3, SSI dtsts=1100, x=y=16'h7FFF, sat=1 → addresses 15,0,1 / 14,15,0; SAT issued; res_mv=1; res_data equals the saturated MR read back.
- Zero length: len=0, sat=0 → no MAC; RD0..RD2 issued on cycles 1-3; res_data equals the current MR.
- Reset mid-MAC: assert reset during the second MAC cycle → ps_mul_en=0 next cycle, state IDLE, res_valid=0; a new command is accepted after reset deasserts.
